// File: rtl/usr_serial_rx.sv
// Serial frame receiver for the universal shift register's sout stream: start, DATA_W data bits,
// optional even parity (enabled by defining USR_RX_PARITY_EN), and stop, with valid/ready word output.
module usr_serial_rx #(
  parameter int DATA_W    = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sin,
  input  logic              sin_vld,
  output logic [DATA_W-1:0] dout,
  output logic              dout_vld,
  input  logic              dout_rdy,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun,
  output logic              parity_err
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DATA   = 3'd1,
`ifdef USR_RX_PARITY_EN
    S_PARITY = 3'd2,
`endif
    S_STOP   = 3'd3,
    S_BREAK  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  sr_q, sr_d;
  logic               drop_q, drop_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic               dout_vld_q, dout_vld_d;
  logic               busy_q, busy_d;
  logic               frame_err_q, frame_err_d;
  logic               overrun_q, overrun_d;
  logic               parity_err_q, parity_err_d;

  // Shift-left places the first received bit at the MSB; shift-right places it at the LSB.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] sr, input logic b);
    logic [DATA_W:0] t;
    if (MSB_FIRST) begin
      t = {sr, b};
      return t[DATA_W-1:0];
    end else begin
      t = {b, sr};
      return t[DATA_W:1];
    end
  endfunction

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    drop_d       = drop_q;
    dout_d       = dout_q;
    dout_vld_d   = dout_vld_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    parity_err_d = 1'b0;

    if (dout_vld_q && dout_rdy) dout_vld_d = 1'b0;

    if (sin_vld) begin
      case (state_q)
        S_IDLE: begin
          if (!sin) begin
            state_d = S_DATA;
            cnt_d   = '0;
            drop_d  = 1'b0;
          end
        end
        S_DATA: begin
          sr_d = shift_in(sr_q, sin);
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            cnt_d = '0;
`ifdef USR_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
`ifdef USR_RX_PARITY_EN
        S_PARITY: begin
          if (sin != ^sr_q) begin
            parity_err_d = 1'b1;
            drop_d       = 1'b1;
          end
          state_d = S_STOP;
        end
`endif
        S_STOP: begin
          if (sin) begin
            state_d = S_IDLE;
            if (!drop_q) begin
              // A word leaving this cycle frees the register for the new one.
              if (!dout_vld_q || dout_rdy) begin
                dout_d     = sr_q;
                dout_vld_d = 1'b1;
              end else begin
                overrun_d = 1'b1;
              end
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
        S_BREAK: begin
          if (sin) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      sr_q         <= '0;
      drop_q       <= 1'b0;
      dout_q       <= '0;
      dout_vld_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      drop_q       <= drop_d;
      dout_q       <= dout_d;
      dout_vld_q   <= dout_vld_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_vld   = dout_vld_q;
  assign busy       = busy_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign parity_err = parity_err_q;

endmodule
